// File: rtl/output_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small write FIFO and status flags.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module output_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [7:0]  DATA_ADDR    = 8'hE2,
    parameter logic [7:0]  CTRL_ADDR    = 8'hE3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    address,
    input  logic [7:0]                    data_in,
    input  logic                          write,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = AddrW + 1;
    localparam int unsigned BaudW  = $clog2(CLKS_PER_BIT);
    localparam logic [CountW-1:0] DepthC   = CountW'(FIFO_DEPTH);
    localparam logic [BaudW-1:0]  BaudLast = BaudW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StParity} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e              state_q, state_d;
    logic [BaudW-1:0]    baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [AddrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic                pop, push_req, push_ok, ctrl, flush, baud_done;
`ifdef UART_TX_PARITY_EN
    logic                parity_q;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^mem_q[rd_ptr_q];
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        baud_done = (baud_q == BaudLast);
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: tx is computed from the upcoming state so the line is driven by a flop
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
        tx_busy = (state_q != StIdle);
    end

    // FIFO bookkeeping
    always_comb begin
        push_req   = write && (address == DATA_ADDR);
        ctrl       = write && (address == CTRL_ADDR);
        flush      = ctrl && data_in[1];
        push_ok    = push_req && ((count_q != DepthC) || pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        overflow_d = overflow_q;
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end else if (ctrl && data_in[0]) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // A full FIFO with a same-cycle pop overwrites the slot being read, which is safe here
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign tx         = tx_q;
    assign fifo_count = count_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DepthC);
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_output_uart_tx.sv
// Directed self-checking bench for output_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_output_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       write = 1'b0;
    logic       tx, tx_busy, fifo_empty, fifo_full, overflow;
    logic [2:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic line_s [0:255];
    logic busy_s [0:255];

    output_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4),
        .DATA_ADDR   (8'hE2),
        .CTRL_ADDR   (8'hE3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .data_in   (data_in),
        .write     (write),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    // Expected line level i cycles after the start bit begins (idle-high past the frame)
    function automatic logic exp_line(input logic [7:0] b, input int i);
        int bi;
        bi = i / CPB;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
`ifdef UART_TX_PARITY_EN
        if (bi == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        write   = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0;
    endtask

    task automatic sample_line(input int n);
        for (int i = 0; i < n; i++) begin
            line_s[i] = tx;
            busy_s[i] = tx_busy;
            step();
        end
    endtask

    task automatic test_reset();
        int low_cycles;
        repeat (3) step();
        n_tests++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_tests++;
        if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
        n_tests++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_tests++;
        if (tx_busy !== 1'b0 || fifo_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_full: got %b%b expected 00", tx_busy, fifo_full);
        end
        reset = 1'b1;
        low_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1 || tx_busy !== 1'b0) low_cycles++;
        end
        n_tests++;
        if (low_cycles !== 0) begin n_fail++; $display("FAIL reset_idle_line: got %0d active cycles expected 0", low_cycles); end
    endtask

    task automatic test_single_byte();
        bus_write(8'hE2, 8'hA5);
        n_tests++;
        if (tx !== 1'b1 || fifo_count !== 3'd1) begin
            n_fail++; $display("FAIL single_push: got tx=%b count=%0d expected tx=1 count=1", tx, fifo_count);
        end
        step();
        sample_line(FRAME_CYC + 1);
        for (int j = 0; j <= FRAME_CYC; j++) begin
            n_tests++;
            if (line_s[j] !== exp_line(8'hA5, j) || busy_s[j] !== (j < FRAME_CYC)) begin
                n_fail++;
                $display("FAIL single_frame[%0d]: got tx=%b busy=%b expected tx=%b busy=%b",
                         j, line_s[j], busy_s[j], exp_line(8'hA5, j), (j < FRAME_CYC));
            end
        end
    endtask

    task automatic test_overflow();
        int budget;
        for (int i = 0; i < 6; i++) bus_write(8'hE2, 8'(8'h10 + i));
        n_tests++;
        if (overflow !== 1'b1 || fifo_full !== 1'b1 || fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow_set: got ovf=%b full=%b count=%0d expected ovf=1 full=1 count=4",
                     overflow, fifo_full, fifo_count);
        end
        bus_write(8'hE3, 8'h01);
        n_tests++;
        if (overflow !== 1'b0 || fifo_count !== 3'd4) begin
            n_fail++; $display("FAIL overflow_clear: got ovf=%b count=%0d expected ovf=0 count=4", overflow, fifo_count);
        end
        budget = 0;
        while (tx_busy === 1'b1 && budget < 200) begin step(); budget++; end
        // FSM is in IDLE with a full FIFO: this push coincides with a pop
        bus_write(8'hE2, 8'h77);
        n_tests++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0 || fifo_full !== 1'b1 || tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_push_pop: got count=%0d ovf=%b full=%b busy=%b expected 4 0 1 1",
                     fifo_count, overflow, fifo_full, tx_busy);
        end
        budget = 0;
        while (!(fifo_empty === 1'b1 && tx_busy === 1'b0) && budget < 1000) begin step(); budget++; end
        n_tests++;
        if (budget >= 1000) begin n_fail++; $display("FAIL overflow_drain: got timeout expected idle"); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic e, eb;
        n = 2 * FRAME_CYC + 2;
        bus_write(8'hE2, 8'h00);
        bus_write(8'hE2, 8'hFF);
        sample_line(n);
        for (int j = 0; j < n; j++) begin
            e  = (j <= FRAME_CYC) ? exp_line(8'h00, j) : exp_line(8'hFF, j - FRAME_CYC - 1);
            eb = (j != FRAME_CYC) && (j < 2 * FRAME_CYC + 1);
            n_tests++;
            if (line_s[j] !== e || busy_s[j] !== eb) begin
                n_fail++;
                $display("FAIL b2b_frame[%0d]: got tx=%b busy=%b expected tx=%b busy=%b",
                         j, line_s[j], busy_s[j], e, eb);
            end
        end
    endtask

    task automatic test_flush();
        int n;
        n = FRAME_CYC - 10 + 50;
        bus_write(8'hE2, 8'h11);
        bus_write(8'hE2, 8'h22);
        bus_write(8'hE2, 8'h33);
        repeat (8) step();
        n_tests++;
        if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 2", fifo_count); end
        bus_write(8'hE3, 8'h02);
        n_tests++;
        if (fifo_count !== 3'd0 || fifo_empty !== 1'b1) begin
            n_fail++; $display("FAIL flush_count: got %0d expected 0", fifo_count);
        end
        sample_line(n);
        for (int j = 0; j < n; j++) begin
            n_tests++;
            if (line_s[j] !== exp_line(8'h11, 10 + j) || busy_s[j] !== ((10 + j) < FRAME_CYC)) begin
                n_fail++;
                $display("FAIL flush_frame[%0d]: got tx=%b busy=%b expected tx=%b busy=%b", 10 + j,
                         line_s[j], busy_s[j], exp_line(8'h11, 10 + j), ((10 + j) < FRAME_CYC));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int active;
        bus_write(8'hE2, 8'h5A);
        bus_write(8'hE2, 8'hC3);
        step();
        n_tests++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL rst_mid_start: got %b expected 0", tx); end
        #3;
        reset = 1'b0;
        #1;
        n_tests++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got tx=%b busy=%b count=%0d expected 1 0 0", tx, tx_busy, fifo_count);
        end
        #1;
        reset = 1'b1;
        active = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx !== 1'b1 || tx_busy !== 1'b0) active++;
        end
        n_tests++;
        if (active !== 0 || fifo_empty !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_after: got %0d active cycles expected 0", active);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/output_uart_tx.md
# output_uart_tx

Memory-mapped serial transmitter on the processor's 8-bit output bus, alongside the parallel output ports at E0/E1. It captures CPU writes to its data address into a small FIFO and shifts each byte out on a single `tx` line as an 8N1 UART frame. It exposes FIFO and transmitter status so software can pace writes.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range is 2 or more.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, 2 to 16.
- `DATA_ADDR`, 8'hE2: write address that pushes a byte into the FIFO.
- `CTRL_ADDR`, 8'hE3: write address for control commands.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  8  bus address.
- `data_in`  in  8  bus write data.
- `write`  in  1  bus write strobe; qualifies `address` and `data_in` for one cycle.
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high whenever the FSM is not in IDLE.
- `fifo_empty`  out  1  FIFO count is 0.
- `fifo_full`  out  1  FIFO count equals `FIFO_DEPTH`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky flag: a push was dropped.

## Operation
- **Reset values:** `tx`=1, `tx_busy`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_count`=0, `overflow`=0, FSM in IDLE, FIFO pointers 0. Asserting reset mid-frame aborts the frame and forces `tx`=1 immediately.
- **Push:** `write` && `address==DATA_ADDR`.
  - Accepted when count < `FIFO_DEPTH`, or when a pop happens in the same cycle.
  - Otherwise the data is dropped and `overflow` is set to 1.
- **Control:** `write` && `address==CTRL_ADDR`.
  - `data_in[0]`=1 clears `overflow`.
  - `data_in[1]`=1 flushes the FIFO: pointers and count go to 0. A frame already in the shifter completes normally.
  - Flush in the same cycle as a pop leaves count at 0.
- **FIFO:** circular buffer. Read and write pointers wrap modulo `FIFO_DEPTH`. Push and pop in the same cycle leave the count unchanged.
- **FSM states:**
  - IDLE: `tx`=1. If the FIFO is not empty, pop the head into the shift register, clear the bit counter, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, LSB first. Shift right after each bit. After the 8th bit go to PARITY (if compiled in) or STOP.
  - PARITY: `tx`=^byte (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- **Counters:**
  - Baud counter counts 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary.
  - Bit counter is 3 bits wide.
  - Neither counter is affected by bus activity.

## Timing
- **Latency:** a push into an empty FIFO at edge k is popped at edge k+1. `tx` falls after edge k+1; `tx_busy` rises after edge k+1.
- **Frame length:** 10×`CLKS_PER_BIT` cycles (11× with parity).
- **Back-to-back frames:** exactly one IDLE cycle (`tx`=1) between the end of STOP and the next start bit.
- **Status outputs:** `fifo_*` and `overflow` are registered and reflect the state after each edge.
- **Push while full with simultaneous pop:** accepted; count stays at `FIFO_DEPTH`; `overflow` is unchanged.
- `tx` is registered and glitch-free.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and frames are 8E1, 11 bits long.
- Not defined: the PARITY state and its logic are absent and frames are 8N1, 10 bits long.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Reset:** reset low → `tx`=1, `fifo_empty`=1, `fifo_count`=0, `overflow`=0. Release reset with no writes → `tx` stays 1 for 100 cycles.
- **Single byte:** write 8'hA5 to E2 at edge k → `tx` low from k+1 for 4 cycles. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop bit high. `tx_busy` is high for 40 cycles (44 with parity, parity bit 0).
- **Overflow:** write 6 bytes to E2 in consecutive cycles → first byte is popped, next 4 are stored, 6th is dropped. `overflow`=1 and `fifo_full`=1. Then write 8'h01 to E3 → `overflow`=0.
- **Back-to-back:** two queued bytes 8'h00 and 8'hFF → exactly one idle-high cycle between the frames. Serial data matches both bytes.
- **Flush mid-frame:** 3 bytes queued, write 8'h02 to E3 during DATA → current frame completes. `fifo_count`=0 and no further frames are sent.
- **Reset mid-frame:** pulse reset low during the START bit → `tx`=1 asynchronously. FIFO is empty and no frame follows.
